// File: rtl/v810_pkg.sv
// Shared v810 definitions for the instruction prefetch queue.
// Holds the reset vector default, the queue FSM encoding and a helper.
package v810_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hFFFF_FFF0;

    typedef enum logic [0:0] {
        PFQ_FETCH = 1'b0,
        PFQ_FULL  = 1'b1
    } pfq_state_t;

    function automatic logic [1:0] pfq_sat2(input int unsigned n);
        return (n >= 2) ? 2'd2 : n[1:0];
    endfunction

endpackage

// File: rtl/pfq_ram.sv
// Halfword storage for the prefetch queue: two write ports so a whole
// fetched word lands in one cycle, two read ports for head and head+1.
module pfq_ram
    import v810_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we0,
    input  logic [AW-1:0] i_wa0,
    input  logic [15:0]   i_wd0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_wa1,
    input  logic [15:0]   i_wd1,
    input  logic [AW-1:0] i_ra0,
    input  logic [AW-1:0] i_ra1,
    output logic [15:0]   o_rd0,
    output logic [15:0]   o_rd1
);

    logic [15:0] r_mem [DEPTH];

    // Both ports never target the same entry in one cycle.
    always_ff @(posedge i_clk) begin
        if (i_we0) r_mem[i_wa0] <= i_wd0;
        if (i_we1) r_mem[i_wa1] <= i_wd1;
    end

    assign o_rd0 = r_mem[i_ra0];
    assign o_rd1 = r_mem[i_ra1];

endmodule

// File: rtl/prefetch_queue.sv
// v810 instruction prefetch queue: word fetches in, halfwords out to decode.
// Define PREFETCH_QUEUE_BYPASS_EN to forward IF_D into an empty queue.
module prefetch_queue
    import v810_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        FLUSH,
    input  logic [31:0] FLUSH_PC,
    output logic        IF_REQ,
    output logic [29:0] IF_A,
    input  logic        IF_ACK,
    input  logic [31:0] IF_D,
    output logic [15:0] ID_HW0,
    output logic [15:0] ID_HW1,
    output logic [1:0]  ID_VLD,
    output logic [31:0] ID_PC,
    input  logic [1:0]  ID_POP
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pfq_state_t  r_state;
    pfq_state_t  w_state_nxt;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc;
    logic [29:0]   r_ifa;
    logic          r_skip;

    logic          w_req;
    logic          w_xfer;
    logic [1:0]    w_npush;
    logic [1:0]    w_vld_q;
    logic [1:0]    w_vld;
    logic [1:0]    w_npop;
    logic [1:0]    w_pop;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_free;
    logic          w_room;
    logic [15:0]   w_rd0;
    logic [15:0]   w_rd1;
    logic          w_unused_ok;

    assign w_unused_ok = FLUSH_PC[0];

    assign w_xfer  = CE & w_req & IF_ACK & ~FLUSH;
    assign w_npush = w_xfer ? (r_skip ? 2'd1 : 2'd2) : 2'd0;
    assign w_vld_q = pfq_sat2(32'(r_count));

`ifdef PREFETCH_QUEUE_BYPASS_EN
    logic w_byp;
    assign w_byp  = w_xfer & (r_count == '0);
    assign ID_HW0 = w_byp ? (r_skip ? IF_D[31:16] : IF_D[15:0]) : w_rd0;
    assign ID_HW1 = w_byp ? IF_D[31:16] : w_rd1;
    assign w_vld  = w_byp ? w_npush : w_vld_q;
`else
    assign ID_HW0 = w_rd0;
    assign ID_HW1 = w_rd1;
    assign w_vld  = w_vld_q;
`endif

    // Over-asking pops are clipped to what is actually visible.
    assign w_npop = (ID_POP > w_vld) ? w_vld : ID_POP;
    assign w_pop  = (CE & ~FLUSH) ? w_npop : 2'd0;

    assign w_count_nxt = r_count
                       + {{(CW-2){1'b0}}, w_npush}
                       - {{(CW-2){1'b0}}, w_pop};
    assign w_free = CW'(DEPTH) - w_count_nxt;
    assign w_room = (w_free >= CW'(2));

    always_ff @(posedge CLK) begin
        if (!RESn) begin
            r_state <= PFQ_FETCH;
        end else if (CE) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            PFQ_FETCH: if (!w_room) w_state_nxt = PFQ_FULL;
            PFQ_FULL:  if (w_room)  w_state_nxt = PFQ_FETCH;
            default:   w_state_nxt = PFQ_FETCH;
        endcase
        if (FLUSH) w_state_nxt = PFQ_FETCH;
    end

    // Gating with RESn drops a pending request as soon as reset asserts.
    always_comb begin
        w_req = 1'b0;
        unique case (r_state)
            PFQ_FETCH: w_req = RESn;
            PFQ_FULL:  w_req = 1'b0;
            default:   w_req = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_pc    <= {RESET_PC[31:1], 1'b0};
            r_ifa   <= RESET_PC[31:2];
            r_skip  <= RESET_PC[1];
        end else if (CE) begin
            if (FLUSH) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_pc    <= {FLUSH_PC[31:1], 1'b0};
                r_ifa   <= FLUSH_PC[31:2];
                r_skip  <= FLUSH_PC[1];
            end else begin
                if (w_xfer) begin
                    r_ifa  <= r_ifa + 30'd1;
                    r_skip <= 1'b0;
                    r_tail <= r_tail + AW'(w_npush);
                end
                r_head  <= r_head + AW'(w_pop);
                r_pc    <= r_pc + {29'd0, w_pop, 1'b0};
                r_count <= w_count_nxt;
            end
        end
    end

    pfq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk (CLK),
        .i_we0 (w_xfer),
        .i_wa0 (r_tail),
        .i_wd0 (r_skip ? IF_D[31:16] : IF_D[15:0]),
        .i_we1 (w_xfer & ~r_skip),
        .i_wa1 (r_tail + AW'(1)),
        .i_wd1 (IF_D[31:16]),
        .i_ra0 (r_head),
        .i_ra1 (r_head + AW'(1)),
        .o_rd0 (w_rd0),
        .o_rd1 (w_rd1)
    );

    assign IF_REQ = w_req;
    assign IF_A   = r_ifa;
    assign ID_VLD = w_vld;
    assign ID_PC  = r_pc;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed and scoreboard bench for prefetch_queue (default DEPTH=8).
// Honours PREFETCH_QUEUE_BYPASS_EN for the same-cycle visibility checks.
module tb_prefetch_queue;

    localparam int DEPTH = 8;

    logic        CLK;
    logic        RESn;
    logic        CE;
    logic        FLUSH;
    logic [31:0] FLUSH_PC;
    logic        IF_REQ;
    logic [29:0] IF_A;
    logic        IF_ACK;
    logic [31:0] IF_D;
    logic [15:0] ID_HW0;
    logic [15:0] ID_HW1;
    logic [1:0]  ID_VLD;
    logic [31:0] ID_PC;
    logic [1:0]  ID_POP;

    logic        fixed_en;
    logic [31:0] fixed_d;

    int n_vec = 0;
    int n_bad = 0;

    prefetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RESn     (RESn),
        .CE       (CE),
        .FLUSH    (FLUSH),
        .FLUSH_PC (FLUSH_PC),
        .IF_REQ   (IF_REQ),
        .IF_A     (IF_A),
        .IF_ACK   (IF_ACK),
        .IF_D     (IF_D),
        .ID_HW0   (ID_HW0),
        .ID_HW1   (ID_HW1),
        .ID_VLD   (ID_VLD),
        .ID_PC    (ID_PC),
        .ID_POP   (ID_POP)
    );

    function automatic logic [31:0] word_of(input logic [29:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    function automatic logic [15:0] hw_of(input logic [31:0] pc);
        logic [31:0] w;
        w = word_of(pc[31:2]);
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    assign IF_D = fixed_en ? fixed_d : word_of(IF_A);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        int ev;
        int pop;
        logic skip;
        logic ack;
        logic ce;
        logic xfer;
        logic [31:0] pc;

        RESn = 1'b0; CE = 1'b1; FLUSH = 1'b0; FLUSH_PC = '0;
        IF_ACK = 1'b0; ID_POP = 2'd0;
        fixed_en = 1'b0; fixed_d = '0;
        tick();
        tick();
        chk("rst_vld", 32'(ID_VLD), 0);
        chk("rst_req", 32'(IF_REQ), 0);
        chk("rst_pc", ID_PC, 32'hFFFFFFF0);
        chk("rst_ifa", 32'(IF_A), 32'h3FFFFFFC);

        // first fetch after reset release
        fixed_en = 1'b1; fixed_d = 32'h9A00445F;
        IF_ACK = 1'b1; RESn = 1'b1;
        #1;
        chk("first_req", 32'(IF_REQ), 1);
`ifdef PREFETCH_QUEUE_BYPASS_EN
        chk("byp_vld", 32'(ID_VLD), 2);
        chk("byp_hw0", 32'(ID_HW0), 32'h445F);
`else
        chk("nobyp_vld", 32'(ID_VLD), 0);
`endif
        tick();
        fixed_en = 1'b0;
        chk("f1_vld", 32'(ID_VLD), 2);
        chk("f1_hw0", 32'(ID_HW0), 32'h445F);
        chk("f1_hw1", 32'(ID_HW1), 32'h9A00);
        chk("f1_pc", ID_PC, 32'hFFFFFFF0);
        chk("f1_ifa", 32'(IF_A), 32'h3FFFFFFD);

        // fill with no pops
        n = 0;
        for (int i = 0; i < 10 && IF_REQ; i++) begin
            tick();
            n++;
        end
        chk("fill_cycles", n, 3);
        chk("full_req", 32'(IF_REQ), 0);
        chk("full_ifa_wrap", 32'(IF_A), 0);
        tick();
        chk("full_hold_req", 32'(IF_REQ), 0);
        chk("full_hold_ifa", 32'(IF_A), 0);
        chk("full_hw0", 32'(ID_HW0), 32'h445F);
        ID_POP = 2'd2;
        tick();
        ID_POP = 2'd0;
        chk("pop_req_rise", 32'(IF_REQ), 1);
        chk("pop_pc", ID_PC, 32'hFFFFFFF4);
        chk("pop_hw0", 32'(ID_HW0), 32'(hw_of(32'hFFFFFFF4)));
        chk("pop_hw1", 32'(ID_HW1), 32'(hw_of(32'hFFFFFFF6)));

        // flush with simultaneous ack and pop
        FLUSH = 1'b1; FLUSH_PC = 32'h80000006; ID_POP = 2'd2;
        tick();
        FLUSH = 1'b0; ID_POP = 2'd0; IF_ACK = 1'b0;
        chk("fl_vld", 32'(ID_VLD), 0);
        chk("fl_ifa", 32'(IF_A), 32'h20000001);
        chk("fl_req", 32'(IF_REQ), 1);
        chk("fl_pc", ID_PC, 32'h80000006);
        IF_ACK = 1'b1;
        tick();
        IF_ACK = 1'b0;
        chk("odd_vld", 32'(ID_VLD), 1);
        chk("odd_pc", ID_PC, 32'h80000006);
        chk("odd_hw0", 32'(ID_HW0), 32'(word_of(30'h20000001) >> 16));
        chk("odd_ifa", 32'(IF_A), 32'h20000002);
        tick();
        chk("stall_ifa", 32'(IF_A), 32'h20000002);
        chk("stall_vld", 32'(ID_VLD), 1);
        IF_ACK = 1'b1;
        tick();
        chk("odd2_vld", 32'(ID_VLD), 2);
        chk("odd2_hw1", 32'(ID_HW1), 32'(hw_of(32'h80000008)));
        tick();
        chk("cnt5_ifa", 32'(IF_A), 32'h20000004);

        // reset mid-fill with count 5, CE low
        RESn = 1'b0; CE = 1'b0;
        #1;
        chk("rst_req_drop", 32'(IF_REQ), 0);
        tick();
        chk("rst2_vld", 32'(ID_VLD), 0);
        chk("rst2_req", 32'(IF_REQ), 0);
        chk("rst2_pc", ID_PC, 32'hFFFFFFF0);
        chk("rst2_ifa", 32'(IF_A), 32'h3FFFFFFC);
        IF_ACK = 1'b0; CE = 1'b1; RESn = 1'b1;

        // scoreboard run from an odd halfword address
        FLUSH = 1'b1; FLUSH_PC = 32'h00001003;
        tick();
        FLUSH = 1'b0;
        pc = 32'h00001002; cnt = 0; skip = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            ack = ($urandom_range(0, 3) != 0);
            ce  = ($urandom_range(0, 7) != 0);
            IF_ACK = ack; CE = ce;
            #1;
            xfer = ce && IF_REQ && ack;
            ev = (cnt >= 2) ? 2 : cnt;
`ifdef PREFETCH_QUEUE_BYPASS_EN
            if (cnt == 0 && xfer) ev = skip ? 1 : 2;
`endif
            chk("rv_vld", 32'(ID_VLD), 32'(ev));
            chk("rv_pc", ID_PC, pc);
            if (ev >= 1) chk("rv_hw0", 32'(ID_HW0), 32'(hw_of(pc)));
            if (ev == 2) chk("rv_hw1", 32'(ID_HW1), 32'(hw_of(pc + 32'd2)));
            pop = $urandom_range(0, ev);
            ID_POP = 2'(pop);
            tick();
            ID_POP = 2'd0;
            if (ce) begin
                if (xfer) begin
                    cnt += skip ? 1 : 2;
                    skip = 1'b0;
                end
                cnt -= pop;
                pc += 32'(2 * pop);
            end
            chk("rv_ovf", {31'd0, cnt > DEPTH}, 0);
        end
        IF_ACK = 1'b0; CE = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 8, giving the queue size in halfwords (power of two, at least 4).
REQ-002 The block SHALL have a parameter RESET_PC, default 32'hFFFFFFF0, giving the fetch start address after reset.
REQ-003 CLK  in  1  system clock; the only clock.
REQ-004 RESn  in  1  reset; synchronous, active-low.
REQ-005 CE  in  1  clock enable; all state advances only on CLK rising edges with CE=1.
REQ-006 FLUSH  in  1  redirect request from the execution unit (branch, exception or reset vector).
REQ-007 FLUSH_PC  in  32  new fetch address; bit 0 is ignored.
REQ-008 IF_REQ  out  1  word fetch request to the instruction cache.
REQ-009 IF_A  out  30  word address of the fetch (byte address bits 31:2).
REQ-010 IF_ACK  in  1  cache acknowledge; a transfer occurs on a CE cycle with IF_REQ=1 and IF_ACK=1.
REQ-011 IF_D  in  32  fetched word; IF_D[15:0] is the lower address.
REQ-012 ID_HW0  out  16  halfword at the queue head.
REQ-013 ID_HW1  out  16  halfword following the head.
REQ-014 ID_VLD  out  2  number of valid head halfwords, saturated at 2.
REQ-015 ID_PC  out  32  byte address of ID_HW0 (bit 0 = 0).
REQ-016 ID_POP  in  2  halfwords consumed by the decoder this CE cycle (0, 1 or 2).

Function
REQ-017 The queue SHALL be a circular halfword buffer with head pointer, tail pointer and occupancy count, all wrapping modulo DEPTH.
REQ-018 The block SHALL run an FSM with states FETCH (IF_REQ=1) and FULL (IF_REQ=0).
REQ-019 FETCH SHALL go to FULL when free space after this cycle's push/pop is less than 2 halfwords; FULL SHALL go to FETCH when that free space is at least 2.
REQ-020 IF_A SHALL stay stable while IF_REQ=1 and no transfer occurs; IF_A SHALL increment by 1 after each transfer.
REQ-021 A transfer SHALL push both halfwords in the same cycle, except the first transfer after an odd-halfword FLUSH_PC, which pushes only IF_D[31:16].
REQ-022 A pop SHALL advance the head by ID_POP and advance ID_PC by 2*ID_POP, modulo 2^32.
REQ-023 A push and a pop in the same cycle SHALL both take effect; the count changes by the net amount.
REQ-024 When ID_POP exceeds ID_VLD, the block SHALL pop only ID_VLD halfwords; the bench treats such a pop as a protocol error.
REQ-025 On FLUSH in a CE cycle, the block SHALL take these actions:
- empty the queue;
- discard any IF_ACK transfer and any ID_POP in that cycle;
- load ID_PC = {FLUSH_PC[31:1],1'b0} and IF_A = FLUSH_PC[31:2];
- enter FETCH.
REQ-026 FLUSH SHALL have priority over every simultaneous event.
REQ-027 The first IF_REQ for the new address SHALL be asserted in the cycle after FLUSH.
REQ-028 ID_HW0 and ID_HW1 SHALL be registered-queue reads; their values SHALL be don't-care beyond ID_VLD.
REQ-029 Without bypass, latency from a transfer to its halfword appearing at ID_HW0 SHALL be one CE cycle.
REQ-030 IF_A SHALL wrap from 30'h3FFFFFFF to 0 without special handling.

Reset
REQ-031 When RESn=0 on a CLK edge, regardless of CE, the block SHALL reset to:
- queue empty, ID_VLD=0;
- ID_PC=RESET_PC, IF_A=RESET_PC[31:2], IF_REQ=0;
- state FETCH.
REQ-032 IF_REQ SHALL assert on the first CE cycle after RESn rises.
REQ-033 A reset asserted while a request is outstanding SHALL abandon the request; the cache does not complete it.

Configuration
REQ-034 With PREFETCH_QUEUE_BYPASS_EN defined, a transfer into an empty queue SHALL drive ID_HW0/ID_HW1/ID_VLD combinationally from IF_D in the same cycle, and a same-cycle pop SHALL consume from the bypassed data.
REQ-035 Without PREFETCH_QUEUE_BYPASS_EN, ID_* SHALL depend only on registered state, and IF_D SHALL have no combinational path to outputs.

Structure
REQ-036 The shared v810 package SHALL hold RESET_PC_DEFAULT and an enum pfq_state_t {PFQ_FETCH, PFQ_FULL}.
REQ-037 The halfword storage SHALL be a sub-module pfq_ram: dual write port for a word push and two read ports for head and head+1.

Verification
REQ-038 Release reset; cache acks every cycle with IF_D=32'h9A00445F at IF_A=30'h3FFFFFFC -> IF_REQ is high on the first CE cycle; next cycle ID_VLD=2, ID_HW0=16'h445F, ID_HW1=16'h9A00, ID_PC=32'hFFFFFFF0.
REQ-039 With no pops and continuous acks, the queue fills -> IF_REQ falls when count=DEPTH; ID_POP=2 -> IF_REQ rises the next cycle.
REQ-040 FLUSH with FLUSH_PC=32'h80000006 in a cycle with IF_ACK=1 and ID_POP=2 -> ack and pop are ignored; next cycle IF_A=30'h20000001 and IF_REQ=1; after that transfer, ID_VLD=1, ID_PC=32'h80000006, ID_HW0=IF_D[31:16].
REQ-041 Mixed pops of 1 and 2 with random ack stalls over 1000 cycles -> popped halfword stream equals the scoreboard memory image, count never exceeds DEPTH, and a pop never exceeds ID_VLD.
REQ-042 With the macro defined, an ack into an empty queue -> ID_VLD=2 in the same cycle; with it undefined -> ID_VLD=2 one cycle later.
REQ-043 RESn low mid-fill with count=5 -> next cycle ID_VLD=0, IF_REQ=0, ID_PC=32'hFFFFFFF0.
